// File: rtl/regfile_arb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_arb_pkg : shared types and constants for the register file
//                   write-port arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam logic [4:0] ZERO_REG = 5'd31;
   localparam int         NUM_REGS = 32;

endpackage

`default_nettype wire

// File: rtl/enabledDecoder1_2.sv
// ---------------------------------------------------------------------------
// enabledDecoder1_2 : 1-to-2 decoder with enable; all outputs low when
//                     disabled.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module enabledDecoder1_2 (
   input  logic       sel,
   input  logic       en,
   output logic [1:0] dec
);

   assign dec = {en & sel, en & ~sel};

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter : round-robin burst arbiter for the two register
//                         file write sources; X31 writes are swallowed.
//                         Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int LEN_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [LEN_W-1:0]  len0,
   input  logic [LEN_W-1:0]  len1,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   arb_state_t        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_served_q, last_served_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        done_q, done_d;

   logic              busy;
   logic              winner;
   logic [1:0]        gnt_vec;

   assign busy = (state_q == BUSY);

   // On a tie the requester not served last time wins; otherwise the lone requester.
   assign winner = (req0 && req1) ? ~last_served_q : req1;

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_served_d = last_served_q;
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      done_d        = 2'b00;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d = BUSY;
               owner_d = winner;
               addr_d  = winner ? addr1 : addr0;
               cnt_d   = winner ? len1  : len0;
            end
         end
         BUSY: begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - LEN_W'(1);
            if (cnt_q == '0) begin
               state_d         = IDLE;
               last_served_d   = owner_q;
               done_d[owner_q] = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         last_served_q <= 1'b1;
         addr_q        <= '0;
         cnt_q         <= '0;
         done_q        <= 2'b00;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_served_q <= last_served_d;
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
         done_q        <= done_d;
      end
   end

   enabledDecoder1_2 u_gnt_dec (
      .sel (owner_q),
      .en  (busy),
      .dec (gnt_vec)
   );

   assign gnt0    = gnt_vec[0];
   assign gnt1    = gnt_vec[1];
   assign done0   = done_q[0];
   assign done1   = done_q[1];

   // Beats to X31 still advance the burst; only the write strobe is withheld.
   assign wr_en   = busy && (addr_q != ADDR_W'(ZERO_REG));
   assign wr_addr = addr_q;
   assign wr_data = busy ? (owner_q ? data1 : data0) : '0;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter : scoreboard bench for regfile_write_arbiter.
//                            Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [4:0]  addr0, addr1, len0, len1;
   logic [63:0] data0, data1;
   logic        gnt0, gnt1, done0, done1, wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;

   regfile_write_arbiter #(.DATA_W(64), .ADDR_W(5), .LEN_W(5)) dut (
      .clk     (clk),
      .reset   (reset),
      .req0    (req0),
      .req1    (req1),
      .addr0   (addr0),
      .addr1   (addr1),
      .len0    (len0),
      .len1    (len1),
      .data0   (data0),
      .data1   (data1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .done0   (done0),
      .done1   (done1),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [4:0]  exp_addr[$];
   logic [63:0] exp_data[$];
   logic [63:0] drv0[$], drv1[$];
   int          exp_len0[$], exp_len1[$];
   int          bursts0 = 0, bursts1 = 0, dones0 = 0, dones1 = 0;
   bit          gnt1_seen = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Queue a burst: driver beats, expected register writes and expected grant length.
   task automatic issue(input int r, input logic [4:0] a, input logic [4:0] l, input logic [63:0] base);
      logic [4:0] ea;
      for (int i = 0; i <= int'(l); i++) begin
         ea = a + 5'(i);
         if (r == 0) drv0.push_back(base + 64'(i));
         else        drv1.push_back(base + 64'(i));
         if (ea != 5'd31) begin
            exp_addr.push_back(ea);
            exp_data.push_back(base + 64'(i));
         end
      end
      if (r == 0) begin
         exp_len0.push_back(int'(l) + 1);
         bursts0++;
         addr0 = a; len0 = l; req0 = 1'b1;
      end else begin
         exp_len1.push_back(int'(l) + 1);
         bursts1++;
         addr1 = a; len1 = l; req1 = 1'b1;
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((exp_addr.size() != 0 || gnt0 || gnt1) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check_val("idle_timeout", (k >= 200), 0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
   endtask

   // Requester model: drop req once granted, present one beat per granted cycle.
   initial forever begin
      @(posedge clk); #1;
      if (gnt0) begin
         req0 = 1'b0;
         data0 = (drv0.size() != 0) ? drv0.pop_front() : 64'hDEAD_0000;
      end
      if (gnt1) begin
         req1 = 1'b0;
         data1 = (drv1.size() != 0) ? drv1.pop_front() : 64'hDEAD_1111;
      end
   end

   // Output monitor and scoreboard.
   initial begin
      int  streak0, streak1;
      bit  pg0, pg1;
      streak0 = 0; streak1 = 0; pg0 = 1'b0; pg1 = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            streak0 = 0; streak1 = 0; pg0 = 1'b0; pg1 = 1'b0;
         end else begin
            check_val("gnt_onehot", gnt0 & gnt1, 0);
            check_val("done0", done0, pg0 && !gnt0);
            check_val("done1", done1, pg1 && !gnt1);
            if (done0) dones0++;
            if (done1) dones1++;
            if (gnt1) gnt1_seen = 1'b1;
            if (wr_en) begin
               check_val("wr_pending", exp_addr.size() != 0, 1);
               if (exp_addr.size() != 0) begin
                  check_val("wr_addr", wr_addr, exp_addr.pop_front());
                  check_val("wr_data", wr_data, exp_data.pop_front());
               end
            end
            if (gnt0) streak0++;
            else if (pg0) begin
               check_val("gnt0_pending", exp_len0.size() != 0, 1);
               if (exp_len0.size() != 0) check_val("gnt0_len", streak0, exp_len0.pop_front());
               streak0 = 0;
            end
            if (gnt1) streak1++;
            else if (pg1) begin
               check_val("gnt1_pending", exp_len1.size() != 0, 1);
               if (exp_len1.size() != 0) check_val("gnt1_len", streak1, exp_len1.pop_front());
               streak1 = 0;
            end
            pg0 = gnt0;
            pg1 = gnt1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int         cnt;
      logic [4:0] ea;
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
      data0 = '0; data1 = '0;
      #2;
      check_val("rst_gnt0", gnt0, 0);
      check_val("rst_gnt1", gnt1, 0);
      check_val("rst_done0", done0, 0);
      check_val("rst_done1", done1, 0);
      check_val("rst_wr_en", wr_en, 0);
      check_val("rst_wr_addr", wr_addr, 0);
      check_val("rst_wr_data", wr_data, 0);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;

      // Single 3-beat burst from requester 0.
      gnt1_seen = 1'b0;
      @(negedge clk);
      issue(0, 5'd3, 5'd2, 64'hA);
      wait_idle();
      check_val("t1_gnt1_never", gnt1_seen, 0);

      // Tie straight out of reset, then a second tie.
      do_reset();
      for (int rep = 0; rep < 2; rep++) begin
         @(negedge clk);
         issue(0, 5'd10, 5'd0, 64'h100 + 64'(rep));
         issue(1, 5'd20, 5'd0, 64'h200 + 64'(rep));
         @(negedge clk);
         check_val("tie_first_gnt0", gnt0, 1);
         check_val("tie_first_gnt1", gnt1, 0);
         @(negedge clk);
         check_val("tie_turn_gnt0", gnt0, 0);
         check_val("tie_turn_gnt1", gnt1, 0);
         @(negedge clk);
         check_val("tie_second_gnt1", gnt1, 1);
         wait_idle();
      end

      // Address wrap through the zero register.
      @(negedge clk);
      issue(1, 5'd30, 5'd3, 64'h1000);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ea = 5'd30 + 5'(k);
         check_val("wrap_addr", wr_addr, ea);
         check_val("wrap_en", wr_en, (k != 1));
      end
      wait_idle();

      // Maximum burst with the other requester waiting.
      @(negedge clk);
      issue(0, 5'd0, 5'd31, 64'h5000);
      @(negedge clk);
      issue(1, 5'd8, 5'd0, 64'h6000);
      cnt = 0;
      while (gnt0 && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      check_val("max_gnt0_cycles", cnt, 32);
      check_val("max_turn_gnt1", gnt1, 0);
      check_val("max_turn_done0", done0, 1);
      @(negedge clk);
      check_val("max_then_gnt1", gnt1, 1);
      wait_idle();

      // Asynchronous reset during the second beat of a 4-beat burst.
      @(negedge clk);
      issue(0, 5'd4, 5'd3, 64'h7000);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      exp_addr.delete();
      exp_data.delete();
      drv0.delete();
      exp_len0.delete();
      bursts0--;
      #1;
      check_val("arst_gnt0", gnt0, 0);
      check_val("arst_wr_en", wr_en, 0);
      check_val("arst_done0", done0, 0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      @(negedge clk);
      issue(0, 5'd12, 5'd1, 64'h8000);
      wait_idle();

      // Requester drops req right after grant; burst still completes.
      @(negedge clk);
      issue(0, 5'd16, 5'd4, 64'h9000);
      wait_idle();

      check_val("sb_empty", exp_addr.size(), 0);
      check_val("done0_count", dones0, bursts0);
      check_val("done1_count", dones1, bursts1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
